// File: rtl/dcache_controller.sv
// dcache_controller: direct-mapped, write-back, write-allocate data cache
// between the core load/store stage and a line-wide backing memory.
//
// Ports
//   clock, reset                  system clock, asynchronous active-high reset
//   cpu_req_valid/rw/addr/data    one word request from the core (taken in IDLE)
//   cpu_res_ready, cpu_res_data   one-cycle completion pulse and load data
//   cpu_busy                      high whenever the controller is not idle
//   mem_req_valid/rw/addr/data    line transaction to backing memory
//   mem_res_ready, mem_res_data   line transaction completion and refill data
//   hit_count, miss_count         saturating hit / miss statistics
module dcache_controller #(
    parameter int unsigned NUM_LINES = 4,
    parameter int unsigned LINE_W    = 128,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned WORD_W    = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_req_valid,
    input  logic              cpu_req_rw,
    input  logic [ADDR_W-1:0] cpu_req_addr,
    input  logic [WORD_W-1:0] cpu_req_data,
    output logic              cpu_res_ready,
    output logic [WORD_W-1:0] cpu_res_data,
    output logic              cpu_busy,
    output logic              mem_req_valid,
    output logic              mem_req_rw,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [LINE_W-1:0] mem_req_data,
    input  logic              mem_res_ready,
    input  logic [LINE_W-1:0] mem_res_data,
    output logic [15:0]       hit_count,
    output logic [15:0]       miss_count
);

    localparam int unsigned WORDS  = LINE_W / WORD_W;
    localparam int unsigned OFF_W  = $clog2(LINE_W / 8);
    localparam int unsigned WSEL_W = $clog2(WORDS);
    localparam int unsigned BSEL_W = $clog2(WORD_W / 8);
    localparam int unsigned IDX_W  = $clog2(NUM_LINES);
    localparam int unsigned TAG_W  = ADDR_W - IDX_W - OFF_W;

    localparam logic [1:0] S_IDLE       = 2'd0;
    localparam logic [1:0] S_COMPARE    = 2'd1;
    localparam logic [1:0] S_WRITE_BACK = 2'd2;
    localparam logic [1:0] S_ALLOCATE   = 2'd3;

    logic [1:0]        state;
    logic [1:0]        next_state;

    // Latched request
    logic              req_rw;
    logic [TAG_W-1:0]  req_tag;
    logic [IDX_W-1:0]  req_idx;
    logic [WSEL_W-1:0] req_wsel;
    logic [WORD_W-1:0] req_data;
    // Set once the line has been refilled, so the final COMPARE is not counted
    logic              refilled;

    // Line state: valid/dirty are reset, tag/data arrays are not
    logic [NUM_LINES-1:0]           valid_bits;
    logic [NUM_LINES-1:0]           dirty_bits;
    logic [TAG_W-1:0]               tags  [NUM_LINES];
    logic [WORDS-1:0][WORD_W-1:0]   lines [NUM_LINES];

    logic hit;
    logic victim_dirty;

    // Byte-within-word address bits carry no information for word accesses
    logic unused_byte_sel;
    assign unused_byte_sel = ^cpu_req_addr[BSEL_W-1:0];

    // Lookup, next-state and combinational output decode
    always_comb begin
        next_state    = state;
        hit           = valid_bits[req_idx] && (tags[req_idx] == req_tag);
        victim_dirty  = valid_bits[req_idx] && dirty_bits[req_idx];
        cpu_res_ready = 1'b0;
        cpu_res_data  = '0;
        cpu_busy      = (state != S_IDLE);
        mem_req_valid = 1'b0;
        mem_req_rw    = 1'b0;
        mem_req_addr  = '0;
        mem_req_data  = '0;

        case (state)
            S_IDLE: begin
                if (cpu_req_valid) begin
                    next_state = S_COMPARE;
                end
            end
            S_COMPARE: begin
                if (hit) begin
                    cpu_res_ready = 1'b1;
                    if (!req_rw) begin
                        cpu_res_data = lines[req_idx][req_wsel];
                    end
                    next_state = S_IDLE;
                end else if (victim_dirty) begin
                    next_state = S_WRITE_BACK;
                end else begin
                    next_state = S_ALLOCATE;
                end
            end
            S_WRITE_BACK: begin
                mem_req_valid = 1'b1;
                mem_req_rw    = 1'b1;
                mem_req_addr  = {tags[req_idx], req_idx, {OFF_W{1'b0}}};
                mem_req_data  = lines[req_idx];
                if (mem_res_ready) begin
                    next_state = S_ALLOCATE;
                end
            end
            S_ALLOCATE: begin
                mem_req_valid = 1'b1;
                mem_req_rw    = 1'b0;
                mem_req_addr  = {req_tag, req_idx, {OFF_W{1'b0}}};
                if (mem_res_ready) begin
                    next_state = S_COMPARE;
                end
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // State, request latch, line status bits and statistics
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            req_rw     <= 1'b0;
            req_tag    <= '0;
            req_idx    <= '0;
            req_wsel   <= '0;
            req_data   <= '0;
            refilled   <= 1'b0;
            valid_bits <= '0;
            dirty_bits <= '0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            state <= next_state;
            case (state)
                S_IDLE: begin
                    if (cpu_req_valid) begin
                        req_rw   <= cpu_req_rw;
                        req_tag  <= cpu_req_addr[ADDR_W-1 -: TAG_W];
                        req_idx  <= cpu_req_addr[OFF_W +: IDX_W];
                        req_wsel <= cpu_req_addr[BSEL_W +: WSEL_W];
                        req_data <= cpu_req_data;
                        refilled <= 1'b0;
                    end
                end
                S_COMPARE: begin
                    if (hit) begin
                        if (req_rw) begin
                            dirty_bits[req_idx] <= 1'b1;
                        end
                        if (!refilled && (hit_count != 16'hFFFF)) begin
                            hit_count <= hit_count + 16'd1;
                        end
                    end else if (miss_count != 16'hFFFF) begin
                        miss_count <= miss_count + 16'd1;
                    end
                end
                S_ALLOCATE: begin
                    if (mem_res_ready) begin
                        valid_bits[req_idx] <= 1'b1;
                        dirty_bits[req_idx] <= 1'b0;
                        refilled            <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Tag and data arrays: refill writes the whole line, store hits merge one word
    always_ff @(posedge clock) begin
        if ((state == S_ALLOCATE) && mem_res_ready) begin
            lines[req_idx] <= mem_res_data;
            tags[req_idx]  <= req_tag;
        end else if ((state == S_COMPARE) && hit && req_rw) begin
            lines[req_idx][req_wsel] <= req_data;
        end
    end

endmodule

// File: doc/dcache_controller.md
Name: dcache_controller

Overview:
- Direct-mapped, write-back, write-allocate data cache controller between the core's load/store stage and the backing data memory.
- Accepts one 32-bit word request at a time from the core.
- Serves hits from its local line array.
- On a miss it issues 128-bit line transactions to the backing memory: a write-back of the dirty victim, then a refill.
- The backing memory has a fixed 5-cycle latency and uses a valid/ready handshake.

Parameters:
- NUM_LINES, 4, number of cache lines; index = addr[5:4].
- LINE_W, 128, line width in bits (4 words).
- ADDR_W, 32, address width; tag = addr[ADDR_W-1:6], word offset = addr[3:2], addr[1:0] ignored.
- WORD_W, 32, core data width.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cpu_req_valid  in  1  core request strobe, sampled only in IDLE
- cpu_req_rw  in  1  0 = load, 1 = store
- cpu_req_addr  in  ADDR_W  byte address
- cpu_req_data  in  WORD_W  store data
- cpu_res_ready  out  1  one-cycle pulse: request complete
- cpu_res_data  out  WORD_W  load data, valid while cpu_res_ready is high, 0 otherwise
- cpu_busy  out  1  high whenever state != IDLE
- mem_req_valid  out  1  memory transaction request
- mem_req_rw  out  1  0 = line read, 1 = line write
- mem_req_addr  out  ADDR_W  line-aligned address; bits [3:0] = 0
- mem_req_data  out  LINE_W  victim line for write-back
- mem_res_ready  in  1  memory transaction done, single-cycle
- mem_res_data  in  LINE_W  refill line, valid while mem_res_ready is high
- hit_count  out  16  saturating count of hits on first lookup
- miss_count  out  16  saturating count of misses

Behaviour:
- Reset (async):
  - State = IDLE.
  - All valid and dirty bits are cleared; tag and data arrays are not cleared.
  - All outputs are 0 and the counters are 0.
  - Reset during any memory transaction drops mem_req_valid in the same cycle and discards the in-flight request.
- IDLE:
  - When cpu_req_valid = 1, latch rw, addr and data; next state COMPARE.
  - Otherwise remain in IDLE.
- COMPARE, hit (valid[idx] && tag[idx] == latched tag):
  - Load: cpu_res_ready = 1, cpu_res_data = data[idx][offset*32 +: 32].
  - Store: write the word into data[idx] at the clock edge and set dirty[idx]; cpu_res_ready = 1, cpu_res_data = 0.
  - Next state IDLE.
- COMPARE, miss:
  - Victim dirty: next state WRITE_BACK.
  - Victim clean or invalid: next state ALLOCATE.
- Counter updates:
  - hit_count increments only on a hit in the first COMPARE of a request.
  - miss_count increments on each miss.
  - The COMPARE re-entered after a refill counts nothing.
  - Both counters saturate at 0xFFFF.
- WRITE_BACK:
  - Drive mem_req_valid = 1, mem_req_rw = 1, mem_req_addr = {tag[idx], idx, 4'b0}, mem_req_data = data[idx].
  - Hold all of these stable until mem_res_ready; then next state ALLOCATE.
- ALLOCATE:
  - Drive mem_req_valid = 1, mem_req_rw = 0, mem_req_addr = {latched tag, idx, 4'b0}.
  - Hold them stable until mem_res_ready.
  - On mem_res_ready: data[idx] <= mem_res_data, tag updated, valid = 1, dirty = 0; next state COMPARE, which now hits and completes the request (store merges the word there).
- Memory-side signals are decoded combinationally from state plus registered request and line arrays.
  - mem_req_valid is 0 in IDLE and COMPARE.
  - mem_req_data is 0 outside WRITE_BACK.
- Latency, with request accepted in cycle 0:
  - Hit: response in cycle 1.
  - Clean miss: mem_req_valid rises in cycle 2, mem_res_ready in cycle 8, response in cycle 9.
  - Dirty miss: write-back done in cycle 8, refill issued in cycle 9, refill done in cycle 15, response in cycle 16.
- cpu_req_valid outside IDLE is ignored; the core must stall on cpu_busy.
- mem_res_ready seen in IDLE or COMPARE is ignored.
- Zero-latency memory (ready in the first request cycle) must work: one cycle per memory state.

Test Plan:
1. Reset, preload memory line 1 = {0x33,0x22,0x11,0x00} (word3..0); load 0x14 -> mem read addr 0x10 issued in cycle 2, cpu_res_ready in cycle 9 with data 0x11, miss_count = 1.
2. Load 0x18 following scenario 1 -> cpu_res_ready in cycle 1, data 0x22, mem_req_valid never asserted, hit_count = 1.
3. Store 0x14 = 0xDEADBEEF (hit) -> response in cycle 1, no memory traffic; load 0x14 -> 0xDEADBEEF.
4. Load 0x54 (same index 1, new tag) after scenario 3 -> mem write addr 0x10 with data bits[63:32] = 0xDEADBEEF, then mem read addr 0x50; response in cycle 16; a later load of 0x14 misses again.
5. Store miss to clean line 0x28 = 0xCAFEF00D -> only a refill read of 0x20, no write-back; response in cycle 9; load 0x28 hits with 0xCAFEF00D and dirty[2] = 1.
6. Assert reset in cycle 4 of an ALLOCATE -> mem_req_valid, cpu_busy and the counters are 0 in the same cycle; after release, load 0x18 misses (line invalidated).
